clock_period_meter: RTL

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_meter_pkg.sv | 12 +
 rtl/sync_rise_detect.sv | 29 ++
 rtl/clock_period_meter.sv | 83 ++++++++
 3 files changed

// File: rtl/clock_meter_pkg.sv
// Shared types and defaults for the clock period meter slice.
// Holds the measurement FSM state encoding and the default counter width.
package clock_meter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [0:0] {
    ARM     = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous slow signal into the clock_in domain and flags its rising edges.
// sig_s is the synchronized level; rise is a one-cycle strobe derived purely from flops.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic sig_in,
  output logic sig_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sig_d_reg;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_reg  <= '0;
      sig_d_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      sig_d_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_reg[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d_reg;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow signal in clock_in cycles.
// The first rise after reset or timeout only arms the meter; each later rise publishes a result.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic [WIDTH-1:0] timeout_limit,
  output logic [WIDTH-1:0] period_count,
  output logic [WIDTH-1:0] high_count,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] hcnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] hcnt_next;
  logic             sig_s;
  logic             rise;
  logic             timeout_hit;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock_in(clock_in),
    .reset   (reset),
    .sig_in  (sig_in),
    .sig_s   (sig_s),
    .rise    (rise)
  );

  // Counters saturate so a stalled signal never wraps into a plausible short period.
  assign cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
  assign hcnt_next   = (hcnt_reg == CNT_MAX) ? hcnt_reg : hcnt_reg + CNT_ONE;
  assign timeout_hit = (timeout_limit != '0) && (cnt_reg == timeout_limit) && !rise;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_reg    <= ARM;
      cnt_reg      <= '0;
      hcnt_reg     <= '0;
      period_count <= '0;
      high_count   <= '0;
      meas_valid   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rise) begin
        // A rise always wins over a coincident timeout compare.
        state_reg <= MEASURE;
        cnt_reg   <= CNT_ONE;
        hcnt_reg  <= CNT_ONE;
        if (state_reg == MEASURE) begin
          period_count <= cnt_reg;
          high_count   <= hcnt_reg;
          meas_valid   <= 1'b1;
          timeout      <= 1'b0;
        end
      end else if (timeout_hit) begin
        state_reg <= ARM;
        cnt_reg   <= '0;
        hcnt_reg  <= '0;
        timeout   <= 1'b1;
      end else begin
        // In ARM the count keeps running so a dead input still times out.
        cnt_reg <= cnt_next;
        if (state_reg == MEASURE && sig_s) begin
          hcnt_reg <= hcnt_next;
        end
      end
    end
  end

endmodule
